// File: rtl/sample_dump.sv
// sample_dump: dumps SDRAM words 0..LAST_ADDR to the serial transmitter, each word sent LSB byte first.
// Ports: clk, rst (sync, active-high); start pulse; SDRAM read side addr/in_valid/busy/data_out/out_valid;
//   serial side tx_data/new_tx_data/tx_busy; status active (RUN/DRAIN/CSUM) and done (DONE).
// Option: define SAMPLE_DUMP_CHECKSUM_EN to append one XOR-of-all-data-bytes checksum byte per dump.
module sample_dump #(
  parameter int                ADDR_W     = 23,
  parameter int                DATA_W     = 32,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] LAST_ADDR  = 23'h7FFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] addr,
  output logic              in_valid,
  input  logic              busy,
  input  logic [DATA_W-1:0] data_out,
  input  logic              out_valid,
  output logic [7:0]        tx_data,
  output logic              new_tx_data,
  input  logic              tx_busy,
  output logic              active,
  output logic              done
);

  localparam int NB = DATA_W / 8;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(NB + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] NB_C    = BW'(NB);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
`ifdef SAMPLE_DUMP_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t state, nstate;

  logic [ADDR_W-1:0] cur_addr;
  logic [CW-1:0]     credits;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     fcnt;
  logic [DATA_W-1:0] sh;        // word being serialized, shifted right per byte
  logic [BW-1:0]     ser_cnt;   // bytes still to send; 0 = serializer idle
  logic              guard;     // one dead cycle after every strobe
  logic              req, push, pop, strobe, last_strobe, start_ok, csum_strobe;
`ifdef SAMPLE_DUMP_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  // Next-state logic
  always_comb begin
    nstate = state;
    case (state)
      S_IDLE, S_DONE: if (start) nstate = S_RUN;
      S_RUN:          if (req && cur_addr == LAST_ADDR) nstate = S_DRAIN;
      // Zero credits means every requested word has fully left the serializer.
      S_DRAIN: if (credits == '0 && ser_cnt == '0) begin
`ifdef SAMPLE_DUMP_CHECKSUM_EN
        nstate = S_CSUM;
`else
        nstate = S_DONE;
`endif
      end
`ifdef SAMPLE_DUMP_CHECKSUM_EN
      S_CSUM:         if (csum_strobe) nstate = S_DONE;
`endif
      default:        nstate = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    start_ok = start && (state == S_IDLE || state == S_DONE);
    req      = (state == S_RUN) && !busy && (credits < DEPTH_C);
    active   = (state == S_RUN) || (state == S_DRAIN)
`ifdef SAMPLE_DUMP_CHECKSUM_EN
               || (state == S_CSUM)
`endif
               ;
    done     = (state == S_DONE);
  end

  // Datapath strobes and output muxing
  always_comb begin
    push        = out_valid && (state != S_IDLE);   // stale returns after reset are dropped
    pop         = (ser_cnt == '0) && (fcnt != '0);
    strobe      = (ser_cnt != '0) && !guard && !tx_busy;
    last_strobe = strobe && (ser_cnt == BW'(1));
    csum_strobe = 1'b0;
    tx_data     = sh[7:0];
`ifdef SAMPLE_DUMP_CHECKSUM_EN
    if (state == S_CSUM) begin
      csum_strobe = !guard && !tx_busy;
      tx_data     = csum;
    end
`endif
    new_tx_data = strobe || csum_strobe;
    in_valid    = req;
    addr        = cur_addr;
  end

  // FIFO storage needs no reset; occupancy is tracked by fcnt.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr <= '0;
      credits  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fcnt     <= '0;
      sh       <= '0;
      ser_cnt  <= '0;
      guard    <= 1'b0;
`ifdef SAMPLE_DUMP_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      guard <= new_tx_data;

      // Address stays on LAST_ADDR once reached; the request there is the final one.
      if (start_ok)                          cur_addr <= '0;
      else if (req && cur_addr != LAST_ADDR) cur_addr <= cur_addr + ADDR_W'(1);

      if (start_ok)                 credits <= '0;
      else if (req && !last_strobe) credits <= credits + CW'(1);
      else if (!req && last_strobe) credits <= credits - CW'(1);

      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      fcnt <= fcnt + CW'(1);
      else if (!push && pop) fcnt <= fcnt - CW'(1);

      if (pop) begin
        sh      <= mem[rd_ptr];
        ser_cnt <= NB_C;
      end else if (strobe) begin
        sh      <= sh >> 8;
        ser_cnt <= ser_cnt - BW'(1);
      end

`ifdef SAMPLE_DUMP_CHECKSUM_EN
      if (start_ok)    csum <= '0;
      else if (strobe) csum <= csum ^ sh[7:0];
`endif
    end
  end

endmodule

// File: tb/tb_sample_dump.sv
module tb_sample_dump;
  localparam int AW = 23;
  localparam int DW = 32;
  localparam logic [AW-1:0] LA  = 23'd7;
  localparam logic [AW-1:0] LA0 = 23'd0;
`ifdef SAMPLE_DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int NB_TOTAL = (int'(LA) + 1) * 4 + CS;
  localparam int NB0      = 4 + CS;

  logic          clk, rst, start, in_valid, busy, out_valid, new_tx_data, tx_busy, active, done;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_out;
  logic [7:0]    tx_data;
  logic          start0, in_valid0, busy0, out_valid0, new_tx_data0, tx_busy0, active0, done0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] data_out0;
  logic [7:0]    tx_data0;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  logic [31:0] word_tab [8];
  logic [7:0]  exp_q [$];
  int          pend_addr [$];
  int          pend_due [$];
  bit          sb_en = 1'b1;
  int          req_cnt, byte_cnt, first_ov, first_strb, b_at_5th, last_strb_cyc;
  logic [7:0]  csum_m, last_byte;
  logic [31:0] w0 = 32'h0D0C0B0A;
  int          b0_cnt, req0_cnt, bad0_addr;
  bit          pend0;

  sample_dump #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .LAST_ADDR(LA)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .in_valid(in_valid), .busy(busy),
    .data_out(data_out), .out_valid(out_valid), .tx_data(tx_data), .new_tx_data(new_tx_data),
    .tx_busy(tx_busy), .active(active), .done(done));

  sample_dump #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .LAST_ADDR(LA0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .addr(addr0), .in_valid(in_valid0), .busy(busy0),
    .data_out(data_out0), .out_valid(out_valid0), .tx_data(tx_data0), .new_tx_data(new_tx_data0),
    .tx_busy(tx_busy0), .active(active0), .done(done0));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Main DUT: SDRAM model (3-cycle return latency) plus tx-side scoreboard/monitor.
  initial begin : resp_main
    int a;
    logic [31:0] w;
    logic [7:0] e;
    out_valid = 1'b0;
    data_out  = '0;
    last_strb_cyc = -10;
    forever begin
      @(negedge clk);
      cyc++;
      if (in_valid) begin
        if ((req_cnt - byte_cnt / 4) >= 4) begin
          checks++;
          $display("FAIL credit_overrun outstanding=%0d limit=3 before request", req_cnt - byte_cnt / 4);
        end
        if (req_cnt == 4) b_at_5th = byte_cnt;
        req_cnt++;
        pend_addr.push_back(int'(addr));
        pend_due.push_back(cyc + 3);
      end
      if (new_tx_data) begin
        checks++;
        if (tx_busy) $display("FAIL strobe_while_tx_busy byte=%02h", tx_data);
        else if (last_strb_cyc == cyc - 1) $display("FAIL guard_cycle strobes back to back at cyc %0d", cyc);
        else if (!sb_en || exp_q.size() == 0) $display("FAIL stray_byte got=%02h exp=none", tx_data);
        else begin
          e = exp_q.pop_front();
          if (tx_data !== e) $display("FAIL byte got=%02h exp=%02h", tx_data, e);
          else passes++;
        end
        if (first_strb < 0) first_strb = cyc;
        last_strb_cyc = cyc;
        last_byte = tx_data;
        byte_cnt++;
      end
      out_valid = 1'b0;
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        a = pend_addr.pop_front();
        void'(pend_due.pop_front());
        w = word_tab[a % 8];
        out_valid = 1'b1;
        data_out  = w;
        if (first_ov < 0) first_ov = cyc;
        if (sb_en) begin
          for (int b = 0; b < 4; b++) begin
            exp_q.push_back(w[8*b +: 8]);
            csum_m = csum_m ^ w[8*b +: 8];
          end
`ifdef SAMPLE_DUMP_CHECKSUM_EN
          if (a == int'(LA)) exp_q.push_back(csum_m);
`endif
        end
      end
    end
  end

  // LAST_ADDR=0 DUT: 1-cycle SDRAM model and byte checker.
  initial begin : resp_zero
    logic [7:0] e0;
    out_valid0 = 1'b0;
    data_out0  = '0;
    pend0      = 1'b0;
    forever begin
      @(negedge clk);
      if (new_tx_data0) begin
        checks++;
        if (b0_cnt >= NB0) $display("FAIL dut0_stray_byte got=%02h", tx_data0);
        else begin
          if (b0_cnt < 4) e0 = w0[8*b0_cnt +: 8];
          else e0 = w0[7:0] ^ w0[15:8] ^ w0[23:16] ^ w0[31:24];
          if (tx_data0 !== e0) $display("FAIL dut0_byte idx=%0d got=%02h exp=%02h", b0_cnt, tx_data0, e0);
          else passes++;
        end
        b0_cnt++;
      end
      if (in_valid0) begin
        req0_cnt++;
        if (addr0 !== '0) bad0_addr++;
      end
      out_valid0 = pend0;
      data_out0  = w0;
      pend0      = in_valid0 && !rst;
    end
  end

  task automatic prep();
    exp_q.delete();
    csum_m = 8'h00;
    req_cnt = 0;
    byte_cnt = 0;
    first_ov = -1;
    first_strb = -1;
    b_at_5th = -1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; busy = 1'b0; tx_busy = 1'b0;
    start0 = 1'b0; busy0 = 1'b0; tx_busy0 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (addr !== '0) $display("FAIL reset_addr got=%0h exp=0", addr); else passes++;
    checks++; if (in_valid !== 1'b0) $display("FAIL reset_in_valid got=%0b exp=0", in_valid); else passes++;
    checks++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data got=%02h exp=00", tx_data); else passes++;
    checks++; if (new_tx_data !== 1'b0) $display("FAIL reset_new_tx_data got=%0b exp=0", new_tx_data); else passes++;
    checks++; if (active !== 1'b0) $display("FAIL reset_active got=%0b exp=0", active); else passes++;
    checks++; if ({done, done0} !== 2'b00) $display("FAIL reset_done got=%02b exp=00", {done, done0}); else passes++;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic check_dump_end(input string name, input int reqs);
    repeat (4) @(negedge clk);
    checks++; if (exp_q.size() != 0) $display("FAIL %s_missing_bytes got=%0d exp=0", name, exp_q.size()); else passes++;
    checks++; if (byte_cnt != NB_TOTAL) $display("FAIL %s_byte_count got=%0d exp=%0d", name, byte_cnt, NB_TOTAL); else passes++;
    checks++; if (req_cnt != reqs) $display("FAIL %s_requests got=%0d exp=%0d", name, req_cnt, reqs); else passes++;
    checks++; if ({active, done} !== 2'b01) $display("FAIL %s_status got=%02b exp=01", name, {active, done}); else passes++;
  endtask

  task automatic test_stream();
    bit ok;
    for (int i = 0; i < 8; i++) word_tab[i] = 32'h04030201 + i * 32'h04040404;
    prep();
    pulse_start();
    checks++; if (active !== 1'b1) $display("FAIL stream_active got=%0b exp=1", active); else passes++;
    wait_done(1000, ok);
    checks++; if (!ok) $display("FAIL stream_done got=timeout exp=done"); else passes++;
    checks++; if (first_strb - first_ov != 2) $display("FAIL stream_latency got=%0d exp=2", first_strb - first_ov); else passes++;
    check_dump_end("stream", int'(LA) + 1);
  endtask

  task automatic test_busy_hold();
    bit ok;
    int viol;
    prep();
    busy = 1'b1;
    pulse_start();
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (in_valid) viol++;
    end
    checks++; if (viol != 0) $display("FAIL busy_hold_requests got=%0d exp=0", viol); else passes++;
    @(posedge clk); #1 busy = 1'b0;
    #1;
    checks++; if ({in_valid, addr} !== {1'b1, 23'd0}) $display("FAIL busy_release got=%0b/%0h exp=1/0", in_valid, addr); else passes++;
    wait_done(1000, ok);
    checks++; if (!ok) $display("FAIL busy_done got=timeout exp=done"); else passes++;
    check_dump_end("busy", int'(LA) + 1);
  endtask

  task automatic test_credit_limit();
    bit ok;
    prep();
    tx_busy = 1'b1;
    pulse_start();
    repeat (30) @(negedge clk);
    checks++; if (req_cnt != 4) $display("FAIL credit_hold_requests got=%0d exp=4", req_cnt); else passes++;
    checks++; if (byte_cnt != 0) $display("FAIL credit_hold_bytes got=%0d exp=0", byte_cnt); else passes++;
    @(posedge clk); #1 tx_busy = 1'b0;
    wait_done(1000, ok);
    checks++; if (!ok) $display("FAIL credit_done got=timeout exp=done"); else passes++;
    checks++; if (b_at_5th != 4) $display("FAIL credit_fifth_req bytes_before got=%0d exp=4", b_at_5th); else passes++;
    check_dump_end("credit", int'(LA) + 1);
  endtask

`ifdef SAMPLE_DUMP_CHECKSUM_EN
  task automatic test_checksum();
    bit ok;
    for (int i = 0; i < 8; i++) word_tab[i] = 32'h0;
    word_tab[0] = 32'h11223344;
    word_tab[1] = 32'h00000001;
    prep();
    pulse_start();
    wait_done(1000, ok);
    checks++; if (!ok) $display("FAIL csum_done got=timeout exp=done"); else passes++;
    checks++; if (last_byte !== 8'h45) $display("FAIL csum_byte got=%02h exp=45", last_byte); else passes++;
    check_dump_end("csum", int'(LA) + 1);
  endtask
`endif

  task automatic test_back_to_back();
    bit ok;
    for (int run = 0; run < 2; run++) begin
      b0_cnt = 0; req0_cnt = 0; bad0_addr = 0;
      @(posedge clk); #1 start0 = 1'b1;
      @(posedge clk); #1 start0 = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (done0) begin
          ok = 1'b1;
          break;
        end
      end
      repeat (4) @(negedge clk);
      checks++; if (!ok) $display("FAIL b2b_done run=%0d got=timeout exp=done", run); else passes++;
      checks++; if (b0_cnt != NB0) $display("FAIL b2b_bytes run=%0d got=%0d exp=%0d", run, b0_cnt, NB0); else passes++;
      checks++; if (req0_cnt != 1) $display("FAIL b2b_requests run=%0d got=%0d exp=1", run, req0_cnt); else passes++;
      checks++; if (bad0_addr != 0) $display("FAIL b2b_addr run=%0d nonzero_addrs=%0d exp=0", run, bad0_addr); else passes++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int base;
    sb_en = 1'b0;
    prep();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_cnt >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1 rst = 1'b1;
    checks++; if (!ok || pend_addr.size() < 2) $display("FAIL rstmid_outstanding got=%0d exp>=2", pend_addr.size()); else passes++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    base = byte_cnt;
    repeat (12) @(negedge clk);
    checks++; if (byte_cnt != base) $display("FAIL rstmid_bytes got=%0d exp=%0d", byte_cnt - base, 0); else passes++;
    checks++; if (pend_addr.size() != 0) $display("FAIL rstmid_returns_pending got=%0d exp=0", pend_addr.size()); else passes++;
    checks++; if ({in_valid, new_tx_data, active, done} !== 4'b0000)
      $display("FAIL rstmid_ctrl got=%04b exp=0000", {in_valid, new_tx_data, active, done}); else passes++;
    checks++; if ({addr, tx_data} !== '0) $display("FAIL rstmid_data got=%0h/%02h exp=0/00", addr, tx_data); else passes++;
    sb_en = 1'b1;
  endtask

  initial begin
    b0_cnt = 0; req0_cnt = 0; bad0_addr = 0;
    for (int i = 0; i < 8; i++) word_tab[i] = 32'h0;
    prep();
    test_reset();
    test_stream();
    test_busy_hold();
    test_credit_limit();
`ifdef SAMPLE_DUMP_CHECKSUM_EN
    test_checksum();
`endif
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
